apb_regfile_completer: RTL

APB4 completer (slave) with a small memory-mapped register bank; it is the peripheral end of the APB interface driven by the multi-slave AHB-to-APB bridge, and one instance sits on each PSELx output. It decodes the low PADDR bits into word registers and supports byte strobes and a parameterised number of wait states. It flags errors via PSLVERR and exports all register contents to the attached peripheral logic.

---
 rtl/apb_regfile_completer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/apb_regfile_completer.sv
// APB4 completer fronting a small word-addressed register bank with byte strobes,
// programmable wait states, error signalling and a flat export of every register.
module apb_regfile_completer #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          REG_NUM     = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA0B0_0003,
  parameter bit          PRIV_WR     = 1'b1
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic                          PWRITE,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [3:0]                    PSTRB,
  input  logic [2:0]                    PPROT,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [REG_NUM*DATA_WIDTH-1:0] regs_flat
);

  localparam int         IDX_W   = $clog2(REG_NUM);
  localparam logic [9:0] REG_LIM = 10'(REG_NUM);

  typedef enum logic [1:0] {IDLE, ACCESS_WAIT, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [9:0] idx_reg, idx_next;
  logic       wr_reg, wr_next;
  logic       err_reg, err_next;
  logic       load, commit, rd_hit;
  logic [IDX_W-1:0] rd_sel;

  logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs_reg, regs_next;

  logic unused_ok;
  assign unused_ok = ^{PADDR[ADDR_WIDTH-1:12], PPROT[2:1]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    wr_next    = wr_reg;
    err_next   = err_reg;
    load       = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: load = PSEL & ~PENABLE;
      ACCESS_WAIT: begin
        if (!PSEL) begin
          state_next = IDLE;
        end else if (PENABLE) begin
          if (cnt_reg <= 4'd1) state_next = DONE;
          else                 cnt_next   = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        commit = wr_reg & ~err_reg;
        load   = PSEL & ~PENABLE;
        if (!load) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      idx_next   = PADDR[11:2];
      wr_next    = PWRITE;
      cnt_next   = 4'(WAIT_CYCLES);
      err_next   = (PADDR[11:2] >= REG_LIM) | (PADDR[1:0] != 2'b00) |
                   (PWRITE & (PADDR[11:2] == 10'd0)) |
                   (PWRITE & PRIV_WR & ~PPROT[0]);
      state_next = (WAIT_CYCLES == 0) ? DONE : ACCESS_WAIT;
    end
  end

  // Register 0 is a constant ID; the rest take their post-commit value so a
  // read launched in the same cycle as a write sees the new data.
  genvar gi, bi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign regs_next[gi] = ID_VALUE;
      end else begin : g_rw
        for (bi = 0; bi < 4; bi++) begin : g_byte
          assign regs_next[gi][8*bi +: 8] =
            (commit && idx_reg == 10'(gi) && PSTRB[bi]) ? PWDATA[8*bi +: 8]
                                                        : regs_reg[gi][8*bi +: 8];
        end
      end
    end
  endgenerate

  assign rd_sel = idx_next[IDX_W-1:0];
  assign rd_hit = (state_next == DONE) & ~wr_next & ~err_next;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= 10'd0;
      wr_reg      <= 1'b0;
      err_reg     <= 1'b0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      PRDATA      <= '0;
      regs_reg    <= '0;
      regs_reg[0] <= ID_VALUE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      wr_reg    <= wr_next;
      err_reg   <= err_next;
      PREADY    <= (state_next == DONE);
      PSLVERR   <= (state_next == DONE) & err_next;
      PRDATA    <= rd_hit ? regs_next[rd_sel] : '0;
      regs_reg  <= regs_next;
    end
  end

  assign regs_flat = regs_reg;

endmodule
